// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, control codes and arbiter FSM states.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational logic ALU: AND / OR; unsupported codes yield zero.
module alu #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] y
);
  import alu_pkg::*;

  always_comb begin
    y = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared ALU; one operation in flight,
// IDLE -> EXEC -> RESP, response held until the consumer accepts it.
module alu_arbiter #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][DATA_W-1:0] req_a,
  input  logic [1:0][DATA_W-1:0] req_b,
  input  logic [1:0][3:0]        req_op,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err
);
  import alu_pkg::*;

  state_t            state, state_nx;
  logic              prio;
  logic              gnt;
  logic              accept;
  logic [DATA_W-1:0] lat_a, lat_b;
  logic [3:0]        lat_op;
  logic              lat_id;
  logic [DATA_W-1:0] alu_y;
  logic              op_err;

  // prio names the requester favoured on contention; a lone requester always wins
  always_comb begin
    if (&req_valid) gnt = prio;
    else            gnt = ~req_valid[0];
  end

  assign accept    = (state == IDLE) && rst_n && req_valid[gnt];
  assign rsp_valid = (state == RESP);
  assign op_err    = (lat_op != ALU_AND) && (lat_op != ALU_OR);

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          req_ready[gnt] = 1'b1;
          state_nx       = EXEC;
        end
      end
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  alu #(.DATA_W(DATA_W)) u_alu (
    .a  (lat_a),
    .b  (lat_b),
    .op (lat_op),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_op   <= '0;
      lat_id   <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lat_a  <= req_a[gnt];
        lat_b  <= req_b[gnt];
        lat_op <= req_op[gnt];
        lat_id <= gnt;
        prio   <= ~gnt;
      end
      if (state == EXEC) begin
        rsp_data <= alu_y;
        rsp_err  <= op_err;
        rsp_id   <= lat_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with hand-computed results.
module tb_alu_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_a;
  logic [1:0][31:0]  req_b;
  logic [1:0][3:0]   req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  alu_arbiter #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // drive a request and return one step after the accept edge (DUT in EXEC)
  task automatic send(input int unsigned id, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op);
    int unsigned n;
    req_a[id]     = a;
    req_b[id]     = b;
    req_op[id]    = op;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready[id]) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic id, input logic [31:0] data,
                            input logic err);
    int unsigned n;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_id"},    {31'd0, rsp_id},    {31'd0, id});
    chk({tag, "_data"},  rsp_data,           data);
    chk({tag, "_err"},   {31'd0, rsp_err},   {31'd0, err});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_drop"},  {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // reset state, with r0 already requesting
    req_a[0] = 32'hF0F0F0F0; req_b[0] = 32'h0FF0FF00; req_op[0] = 4'b0000;
    req_valid = 2'b01;
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id",    {31'd0, rsp_id},    32'd0);
    chk("rst_rsp_data",  rsp_data,           32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);

    // single op: accepted on first edge after release, response 2 cycles later
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("single_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    chk("single_exec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("single_exec_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    expect_rsp("single", 1'b0, 32'h00F0F000, 1'b0);

    // contention from reset: r0 OR, r1 AND, alternating grants
    rst_n = 1'b0;
    @(posedge clk); #1;
    req_a[0] = 32'hF0F0F0F0; req_b[0] = 32'h0FF0FF00; req_op[0] = 4'b0001;
    req_a[1] = 32'h12345678; req_b[1] = 32'h0F0F0F0F; req_op[1] = 4'b0000;
    req_valid = 2'b11;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("cont_first_ready", {30'd0, req_ready}, 32'd1);
    expect_rsp("cont0", 1'b0, 32'hFFF0FFF0, 1'b0);
    expect_rsp("cont1", 1'b1, 32'h02040608, 1'b0);
    expect_rsp("cont2", 1'b0, 32'hFFF0FFF0, 1'b0);
    expect_rsp("cont3", 1'b1, 32'h02040608, 1'b0);
    req_valid = 2'b00;

    // backpressure: r1 response held 5 cycles while r0 waits
    send(1, 32'h0000FFFF, 32'hFF000000, 4'b0001);
    req_a[0] = 32'hFFFFFFFF; req_b[0] = 32'hA5A5A5A5; req_op[0] = 4'b0000;
    req_valid = 2'b01;
    #1;
    chk("bp_exec_ready", {30'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data",  rsp_data,           32'hFF00FFFF);
      chk("bp_id",    {31'd0, rsp_id},    32'd1);
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_pending_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    expect_rsp("bp_next", 1'b0, 32'hA5A5A5A5, 1'b0);

    // illegal op, with rsp_ready held high outside RESP
    rsp_ready = 1'b1;
    send(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0111);
    expect_rsp("illegal", 1'b0, 32'h00000000, 1'b1);

    // operands changed after accept must not leak into the result
    send(1, 32'hCAFEBABE, 32'hFFFF0000, 4'b0000);
    req_a[1]  = 32'h00000000;
    req_op[1] = 4'b0001;
    expect_rsp("opchg", 1'b1, 32'hCAFE0000, 1'b0);

    // reset while in EXEC aborts the operation
    send(0, 32'h00000001, 32'h00000002, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("rexec_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rexec_ready", {30'd0, req_ready}, 32'd0);
    chk("rexec_data",  rsp_data,           32'd0);
    chk("rexec_id",    {31'd0, rsp_id},    32'd0);
    chk("rexec_err",   {31'd0, rsp_err},   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rexec_quiet", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    send(1, 32'hFFFFFFFF, 32'h0000FFFF, 4'b0000);
    expect_rsp("recover", 1'b1, 32'h0000FFFF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
